svc_soc_io_bridge: RTL and testbench
====================================

# svc_soc_io_bridge

Request/response bridge between the RISC-V core's data-memory port and the SoC MMIO register bank. It accepts one CPU load/store at a time and decodes it against the I/O window. Hits are sequenced onto the bank's io_wen/io_ren strobes; misses return an error response. Optionally, partial-strobe stores are turned into a read-merge-write, because the register bank ignores byte strobes.

## Interface
Parameters:
- IO_BASE, 32'h8000_0000, base of the I/O window.
- IO_MASK, 32'hF000_0000, address bits compared against IO_BASE.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  bridge can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_wstrb  in  4  store byte enables.
- rsp_valid  out  1  one-cycle response pulse; CPU must sink it, no backpressure.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  address outside the I/O window.
- io_wen  out  1  bank write strobe.
- io_waddr  out  32  bank write address.
- io_wdata  out  32  bank write data.
- io_wstrb  out  4  bank write strobe bits.
- io_ren  out  1  bank read strobe.
- io_raddr  out  32  bank read address.
- io_rdata  in  32  bank read data, combinational from io_ren/io_raddr.

## Operation
- Hit: (req_addr & IO_MASK) == IO_BASE. Forwarded addresses have bits [1:0] forced to 0.
- The request is latched on accept (req_valid && req_ready). Bank outputs are driven only from the state register and latched request.
- States and transitions:
  - IDLE: accept a request and go to next state:
    - miss: RESP with err;
    - load: RD;
    - store with wstrb 4'hF: WR;
    - store with wstrb 0: RESP, no-op;
    - store with partial wstrb: RMW_RD (or WR when the macro is off).
  - RD: io_ren=1; capture io_rdata; go to RESP.
  - RMW_RD: io_ren=1; capture merged word; go to WR.
  - WR: io_wen=1, io_wstrb=latched wstrb; go to RESP.
  - RESP: rsp_valid=1; go to IDLE.
- Merge rule: byte i comes from req_wdata when wstrb[i] is set, otherwise from io_rdata.
- All non-asserted strobes are 0. Addresses and data hold their latched values.

## Timing
- Reset values: req_ready=1 (IDLE), every other output 0.
- Latencies, with the accept cycle as T:
  - load: io_ren at T+1, rsp_valid at T+2;
  - full store: io_wen at T+1, rsp at T+2;
  - RMW store: io_ren at T+1, io_wen at T+2, rsp at T+3;
  - miss or no-op: rsp at T+1.
- req_ready is low from T+1 through the RESP cycle. The next accept happens at the earliest in the cycle after RESP.
- Only one transaction is in flight; req_valid asserted while busy simply waits.
- rsp_rdata and rsp_err are valid only while rsp_valid is high; they are 0 otherwise.
- Reset asserted mid-transaction:
  - immediately drops io_wen, io_ren and rsp_valid;
  - returns the FSM to IDLE;
  - the in-flight transaction is lost with no response and no partial bank write.

## Configuration
- SVC_SOC_IO_BRIDGE_RMW_EN defined: partial-strobe stores go through RMW_RD→WR, and io_wdata carries the merged word.
- Macro undefined: partial-strobe stores go directly to WR with raw req_wdata and req_wstrb. The RMW_RD state and merge logic are not compiled.

## Structure
- The shared package svc_soc_io_pkg holds:
  - the state enum (IDLE, RD, RMW_RD, WR, RESP);
  - default IO_BASE and IO_MASK constants;
  - the byte-merge function.
- The block is a single module with no sub-module. The register bank instance sits alongside it at SoC level.

## Test plan
- Load from 0x8000_0004 with the bank returning 0x0000_00A5: io_ren at T+1 with io_raddr 0x8000_0004; rsp_valid at T+2 with rdata 0x0000_00A5 and err 0.
- Store 0x0000_0001 to 0x8000_0000 with wstrb F: io_wen at T+1 with wdata 0x0000_0001; rsp at T+2 with rdata 0.
- Load from 0x1000_0000: rsp at T+1 with err=1 and rdata 0; io_ren and io_wen never assert.
- Macro on, store 0x0000_3C00 with wstrb 4'b0010 while the bank holds 0x0000_00A5: io_ren at T+1, then io_wen at T+2 with wdata 0x0000_3CA5, then rsp at T+3.
- Reset pulsed during the RD cycle of a load: io_ren drops asynchronously; no rsp_valid; req_ready=1 after release.
- Back-to-back loads with req_valid held high: second accept in the cycle after the first RESP; exactly two rsp pulses.

Source files
------------

// File: rtl/svc_soc_io_pkg.sv
// Shared types and helpers for the SoC MMIO bridge: FSM state encoding,
// default I/O window constants and the byte-merge used for read-merge-write.
package svc_soc_io_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD     = 3'd1,
      RMW_RD = 3'd2,
      WR     = 3'd3,
      RESP   = 3'd4
   } state_t;

   localparam logic [31:0] IO_BASE_DEF = 32'h8000_0000;
   localparam logic [31:0] IO_MASK_DEF = 32'hF000_0000;

   // Byte i taken from the store data when its strobe is set, else from the bank.
   function automatic logic [31:0] merge_bytes(input logic [31:0] wdata,
                                               input logic [31:0] rdata,
                                               input logic [3:0]  wstrb);
      logic [31:0] m;
      for (int i = 0; i < 4; i++)
         m[i*8 +: 8] = wstrb[i] ? wdata[i*8 +: 8] : rdata[i*8 +: 8];
      return m;
   endfunction

endpackage

// File: rtl/svc_soc_io_bridge.sv
// CPU data-port to MMIO register-bank bridge, one transaction at a time.
// Define SVC_SOC_IO_BRIDGE_RMW_EN to turn partial-strobe stores into read-merge-write.
module svc_soc_io_bridge
   import svc_soc_io_pkg::*;
#(
   parameter logic [31:0] IO_BASE = IO_BASE_DEF,
   parameter logic [31:0] IO_MASK = IO_MASK_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        io_wen,
   output logic [31:0] io_waddr,
   output logic [31:0] io_wdata,
   output logic [3:0]  io_wstrb,
   output logic        io_ren,
   output logic [31:0] io_raddr,
   input  logic [31:0] io_rdata
);

   state_t      state;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic        hit;

   assign hit = ((req_addr & IO_MASK) == IO_BASE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q  <= {req_addr[31:2], 2'b00};
                  wdata_q <= req_wdata;
                  wstrb_q <= req_wstrb;
                  rdata_q <= '0;
                  err_q   <= 1'b0;
                  if (!hit) begin
                     err_q <= 1'b1;
                     state <= RESP;
                  end else if (!req_write) begin
                     state <= RD;
                  end else if (req_wstrb == 4'hF) begin
                     state <= WR;
                  end else if (req_wstrb == 4'h0) begin
                     state <= RESP;
                  end else begin
`ifdef SVC_SOC_IO_BRIDGE_RMW_EN
                     state <= RMW_RD;
`else
                     state <= WR;
`endif
                  end
               end
            end
            RD: begin
               rdata_q <= io_rdata;
               state   <= RESP;
            end
`ifdef SVC_SOC_IO_BRIDGE_RMW_EN
            RMW_RD: begin
               wdata_q <= merge_bytes(wdata_q, io_rdata, wstrb_q);
               state   <= WR;
            end
`endif
            WR:      state <= RESP;
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Strobes decode straight from the state register so reset drops them at once.
   assign req_ready = (state == IDLE);
   assign io_ren    = (state == RD) || (state == RMW_RD);
   assign io_wen    = (state == WR);
   assign rsp_valid = (state == RESP);
   assign io_raddr  = addr_q;
   assign io_waddr  = addr_q;
   assign io_wdata  = wdata_q;
   assign io_wstrb  = io_wen ? wstrb_q : 4'h0;
   assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
   assign rsp_err   = rsp_valid & err_q;

endmodule

// File: tb/tb_svc_soc_io_bridge.sv
// Self-checking bench for svc_soc_io_bridge: vector table, response scoreboard,
// and hand sequences for mid-transaction reset and back-to-back requests.
module tb_svc_soc_io_bridge;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        io_wen, io_ren;
   logic [31:0] io_waddr, io_wdata, io_raddr, io_rdata;
   logic [3:0]  io_wstrb;
   logic [31:0] bank_word;

   assign io_rdata = bank_word;

   always #5 clk = ~clk;

   svc_soc_io_bridge dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .io_wen(io_wen), .io_waddr(io_waddr), .io_wdata(io_wdata), .io_wstrb(io_wstrb),
      .io_ren(io_ren), .io_raddr(io_raddr), .io_rdata(io_rdata)
   );

   localparam int K_RESP = 0;
   localparam int K_RD   = 1;
   localparam int K_WR   = 2;
   localparam int K_RMW  = 3;
`ifdef SVC_SOC_IO_BRIDGE_RMW_EN
   localparam int K_PART = K_RMW;
   localparam bit RMW_ON = 1'b1;
`else
   localparam int K_PART = K_WR;
   localparam bit RMW_ON = 1'b0;
`endif

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] bank;
      int          kind;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic [31:0] exp_wdata;
   } vec_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   rsp_t sb_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   rsp_cnt = 0;
   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every response pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && rsp_valid) begin
         rsp_t e;
         rsp_cnt++;
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response at %0t", $time);
         end else begin
            e = sb_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
         end
      end
   end

   task automatic idle_inputs();
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_wstrb = '0;
   endtask

   task automatic run_vec(input vec_t v);
      int   n;
      logic e_ren, e_wen;
      rsp_t r;
      @(negedge clk);
      chk("ready_before", {31'h0, req_ready}, 32'h1);
      req_valid = 1'b1;
      req_write = v.wr;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      req_wstrb = v.wstrb;
      bank_word = v.bank;
      r.rdata = v.exp_rdata;
      r.err   = v.exp_err;
      sb_q.push_back(r);
      @(posedge clk);
      #1 idle_inputs();
      n = (v.kind == K_RESP) ? 1 : (v.kind == K_RMW) ? 3 : 2;
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         e_ren = (c == 1) && (v.kind == K_RD || v.kind == K_RMW);
         e_wen = ((c == 1) && v.kind == K_WR) || ((c == 2) && v.kind == K_RMW);
         chk("io_ren", {31'h0, io_ren}, {31'h0, e_ren});
         chk("io_wen", {31'h0, io_wen}, {31'h0, e_wen});
         chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, c == n});
         chk("ready_busy", {31'h0, req_ready}, 32'h0);
         if (e_ren) chk("io_raddr", io_raddr, {v.addr[31:2], 2'b00});
         if (e_wen) begin
            chk("io_waddr", io_waddr, {v.addr[31:2], 2'b00});
            chk("io_wdata", io_wdata, v.exp_wdata);
            chk("io_wstrb", {28'h0, io_wstrb}, {28'h0, v.wstrb});
         end else begin
            chk("io_wstrb_idle", {28'h0, io_wstrb}, 32'h0);
         end
      end
      @(negedge clk);
      chk("ready_after", {31'h0, req_ready}, 32'h1);
      chk("rsp_valid_after", {31'h0, rsp_valid}, 32'h0);
      chk("rsp_rdata_after", rsp_rdata, 32'h0);
      chk("rsp_err_after", {31'h0, rsp_err}, 32'h0);
   endtask

   initial begin
      int   acc_idx[$];
      int   rsp_idx[$];
      rsp_t r;

      vecs[0] = '{1'b0, 32'h8000_0004, 32'h0, 4'h0, 32'h0000_00A5, K_RD,   32'h0000_00A5, 1'b0, 32'h0};
      vecs[1] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 4'hF, 32'h0, K_WR,   32'h0, 1'b0, 32'h0000_0001};
      vecs[2] = '{1'b0, 32'h1000_0000, 32'h0, 4'h0, 32'h1234_5678, K_RESP, 32'h0, 1'b1, 32'h0};
      vecs[3] = '{1'b1, 32'h8000_0000, 32'h0000_3C00, 4'b0010, 32'h0000_00A5, K_PART, 32'h0, 1'b0,
                  RMW_ON ? 32'h0000_3CA5 : 32'h0000_3C00};
      vecs[4] = '{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0, K_RESP, 32'h0, 1'b0, 32'h0};
      vecs[5] = '{1'b0, 32'h8000_0007, 32'h0, 4'h0, 32'hDEAD_BEEF, K_RD, 32'hDEAD_BEEF, 1'b0, 32'h0};
      vecs[6] = '{1'b1, 32'h7FFF_FFFC, 32'h5555_5555, 4'hF, 32'h0, K_RESP, 32'h0, 1'b1, 32'h0};
      vecs[7] = '{1'b0, 32'h8FFF_FFFC, 32'h0, 4'h0, 32'h1234_5678, K_RD, 32'h1234_5678, 1'b0, 32'h0};
      vecs[8] = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'b1001, 32'hAABB_CCDD, K_PART, 32'h0, 1'b0,
                  RMW_ON ? 32'h11BB_CC44 : 32'h1122_3344};

      idle_inputs();
      bank_word = '0;
      rst_n = 1'b0;
      #3;
      chk("rst_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("rst_io_ren", {31'h0, io_ren}, 32'h0);
      chk("rst_io_wen", {31'h0, io_wen}, 32'h0);
      chk("rst_io_waddr", io_waddr, 32'h0);
      chk("rst_io_wdata", io_wdata, 32'h0);
      chk("rst_io_raddr", io_raddr, 32'h0);
      chk("rst_io_wstrb", {28'h0, io_wstrb}, 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) run_vec(vecs[i]);

      // Reset during the RD cycle of a load: transaction vanishes.
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = 32'h8000_000C;
      bank_word = 32'h0000_0077;
      @(posedge clk);
      #1 idle_inputs();
      #2 chk("mid_io_ren_before", {31'h0, io_ren}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk("mid_io_ren_drop", {31'h0, io_ren}, 32'h0);
      chk("mid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("mid_ready", {31'h0, req_ready}, 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("mid_no_rsp", {31'h0, rsp_valid}, 32'h0);
         chk("mid_no_wen", {31'h0, io_wen}, 32'h0);
         chk("mid_ready_after", {31'h0, req_ready}, 32'h1);
      end

      // Back-to-back loads with req_valid held high.
      rsp_cnt = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = 32'h8000_0008;
      bank_word = 32'h0000_005A;
      r.rdata = 32'h0000_005A;
      r.err   = 1'b0;
      sb_q.push_back(r);
      sb_q.push_back(r);
      for (int c = 0; c < 6; c++) begin
         if (c > 0) @(negedge clk);
         if (req_ready) acc_idx.push_back(c);
         if (rsp_valid) rsp_idx.push_back(c);
      end
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("b2b_accepts", acc_idx.size(), 2);
      if (acc_idx.size() == 2) begin
         chk("b2b_first_accept", acc_idx[0], 0);
         chk("b2b_second_accept", acc_idx[1], 3);
      end
      chk("b2b_rsp_count", rsp_idx.size(), 2);
      if (rsp_idx.size() == 2) begin
         chk("b2b_rsp0", rsp_idx[0], 2);
         chk("b2b_rsp1", rsp_idx[1], 5);
      end
      chk("b2b_monitor_rsps", rsp_cnt, 2);

      chk("scoreboard_empty", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
